// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: fetch/decode/execute sequencer for the 8-bit accumulator CPU.
module cpu_control_fsm #(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       z_flag,
  input  logic       mem_ready,
  output logic [1:0] bus_sel,
  output logic       ld_mar,
  output logic       ld_mdr,
  output logic       mdr_src,
  output logic       ld_ir,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       ld_ac,
  output logic       ld_r,
  output logic [2:0] alu_op,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       halted,
  output logic       bus_err,
  output logic       illegal
);
  localparam int CW = WAIT_MAX > 1 ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [4:0] S_IDLE = 5'd0,  S_F1  = 5'd1,  S_F2   = 5'd2,  S_F3   = 5'd3,
                         S_DEC  = 5'd4,  S_A1  = 5'd5,  S_A2   = 5'd6,  S_A3   = 5'd7,
                         S_RD   = 5'd8,  S_EXI = 5'd9,  S_W1   = 5'd10, S_W2   = 5'd11,
                         S_MOVR = 5'd12, S_MVAR = 5'd13, S_ADD = 5'd14, S_SUB  = 5'd15,
                         S_JP   = 5'd16, S_HALT = 5'd17, S_ERR = 5'd18;
  logic [4:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rd_st, wait_st, tmo;
  assign rd_st   = state_q == S_F2 || state_q == S_A2 || state_q == S_RD;
  assign wait_st = rd_st || state_q == S_W2;
  // The limit cycle still honours a late mem_ready, so the timeout needs it low.
  assign tmo     = WAIT_MAX != 0 && cnt_q == CW'(WAIT_MAX) && !mem_ready;
  assign cnt_d   = wait_st && !mem_ready ? cnt_q + CW'(1) : '0;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_F1;
      S_F1:   state_d = S_F2;
      S_F2:   state_d = tmo ? S_ERR : mem_ready ? S_F3 : S_F2;
      S_F3:   state_d = S_DEC;
      S_DEC:
        case (opcode)
          4'h1, 4'h2, 4'h3, 4'h8, 4'h9: state_d = S_A1;
          4'h4: state_d = S_MOVR;
          4'h5: state_d = S_MVAR;
          4'h6: state_d = S_ADD;
          4'h7: state_d = S_SUB;
          4'hF: state_d = S_HALT;
          default: state_d = S_F1;
        endcase
      S_A1:   state_d = S_A2;
      S_A2:   state_d = tmo ? S_ERR : !mem_ready ? S_A2 :
                        opcode == 4'h1 ? S_EXI : (opcode == 4'h2 || opcode == 4'h3) ? S_A3 : S_JP;
      S_A3:   state_d = opcode == 4'h2 ? S_RD : S_W1;
      S_RD:   state_d = tmo ? S_ERR : mem_ready ? S_EXI : S_RD;
      S_W1:   state_d = S_W2;
      S_W2:   state_d = tmo ? S_ERR : mem_ready ? S_F1 : S_W2;
      S_EXI, S_MOVR, S_MVAR, S_ADD, S_SUB, S_JP: state_d = S_F1;
      S_HALT, S_ERR: state_d = state_q;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus_sel = (state_q == S_F3 || state_q == S_A3 || state_q == S_EXI || state_q == S_JP) ? 2'b10 :
                   (state_q == S_W1 || state_q == S_MOVR || state_q == S_ADD || state_q == S_SUB) ? 2'b11 : 2'b00;
  assign ld_mar  = state_q == S_F1 || state_q == S_A1 || state_q == S_A3;
  assign ld_mdr  = (rd_st && mem_ready) || state_q == S_W1;
  assign mdr_src = state_q == S_W1;
  assign ld_ir   = state_q == S_F3;
  assign ld_pc   = state_q == S_JP && (opcode == 4'h8 || z_flag);
  assign inc_pc  = (state_q == S_F2 || state_q == S_A2) && mem_ready;
  assign ld_ac   = state_q == S_EXI || state_q == S_MOVR || state_q == S_ADD || state_q == S_SUB;
  assign ld_r    = state_q == S_MVAR;
  assign alu_op  = state_q == S_ADD ? 3'b001 : state_q == S_SUB ? 3'b010 : 3'b000;
  assign mem_rd  = rd_st;
  assign mem_wr  = state_q == S_W2;
  assign halted  = state_q == S_HALT;
  assign bus_err = state_q == S_ERR;
  assign illegal = state_q == S_DEC && opcode >= 4'hA && opcode <= 4'hE;
endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: scoreboard bench; stimulus queues per-cycle expected outputs, a negedge monitor checks them.
module tb_cpu_control_fsm;
  logic       clk = 0, reset, z_flag, mem_ready;
  logic [3:0] opcode;
  logic [1:0] bus_sel;
  logic       ld_mar, ld_mdr, mdr_src, ld_ir, ld_pc, inc_pc, ld_ac, ld_r;
  logic [2:0] alu_op;
  logic       mem_rd, mem_wr, halted, bus_err, illegal;
  int checks = 0, errors = 0;

  cpu_control_fsm #(.WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z_flag(z_flag), .mem_ready(mem_ready),
    .bus_sel(bus_sel), .ld_mar(ld_mar), .ld_mdr(ld_mdr), .mdr_src(mdr_src), .ld_ir(ld_ir),
    .ld_pc(ld_pc), .inc_pc(inc_pc), .ld_ac(ld_ac), .ld_r(ld_r), .alu_op(alu_op),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted), .bus_err(bus_err), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [17:0] B_MDR = 18'd2 << 16, B_R = 18'd3 << 16;
  localparam logic [17:0] K_MAR = 18'd1 << 15, K_MDR = 18'd1 << 14, K_SRC = 18'd1 << 13,
                          K_IR  = 18'd1 << 12, K_PC  = 18'd1 << 11, K_INC = 18'd1 << 10,
                          K_AC  = 18'd1 << 9,  K_R   = 18'd1 << 8,  A_ADD = 18'd1 << 5,
                          A_SUB = 18'd2 << 5,  K_RD  = 18'd1 << 4,  K_WR  = 18'd1 << 3,
                          K_HLT = 18'd1 << 2,  K_ERR = 18'd1 << 1,  K_ILL = 18'd1;

  typedef struct {
    logic [17:0] e;
    logic        bx;
    string       n;
  } item_t;
  item_t q[$];

  logic [17:0] act;
  assign act = {bus_sel, ld_mar, ld_mdr, mdr_src, ld_ir, ld_pc, inc_pc, ld_ac, ld_r,
                alu_op, mem_rd, mem_wr, halted, bus_err, illegal};

  always @(negedge clk) begin
    item_t it;
    logic [17:0] m;
    if (q.size() != 0) begin
      it = q.pop_front();
      m = it.bx ? 18'h0FFFF : 18'h3FFFF;
      checks++;
      if ((act & m) !== (it.e & m)) begin
        errors++;
        $display("FAIL %s: got %h expected %h (mask %h) at %0t", it.n, act, it.e, m, $time);
      end
    end
  end

  task automatic step(input logic rs, input logic mr, input logic [3:0] op, input logic z,
                      input logic [17:0] e, input logic bx, input string n);
    @(posedge clk);
    #1;
    reset = rs; mem_ready = mr; opcode = op; z_flag = z;
    q.push_back('{e, bx, n});
  endtask

  task automatic fetch(input logic [3:0] op, input int w);
    step(0, 1, op, 0, K_MAR, 0, "F1");
    repeat (w) step(0, 0, op, 0, K_RD, 1, "F2 wait");
    step(0, 1, op, 0, K_RD | K_MDR | K_INC, 1, "F2 done");
    step(0, 1, op, 0, B_MDR | K_IR, 0, "F3");
    step(0, 1, op, 0, (op >= 4'hA && op <= 4'hE) ? K_ILL : 18'd0, 1, "DEC");
  endtask

  task automatic opnd(input logic [3:0] op);
    step(0, 1, op, 0, K_MAR, 0, "A1");
    step(0, 1, op, 0, K_RD | K_MDR | K_INC, 1, "A2");
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 18'd0, 0, "reset idle");
    step(0, 1, 0, 0, 18'd0, 0, "release idle");
  endtask

  initial begin
    reset = 1; mem_ready = 0; opcode = 0; z_flag = 0;
    do_reset();
    fetch(4'h0, 0);
    fetch(4'h1, 0); opnd(4'h1);
    step(0, 1, 4'h1, 0, B_MDR | K_AC, 0, "LDI EXI");
    fetch(4'h2, 0); opnd(4'h2);
    step(0, 1, 4'h2, 0, B_MDR | K_MAR, 0, "LD A3");
    repeat (3) step(0, 0, 4'h2, 0, K_RD, 1, "LD RD wait");
    step(0, 1, 4'h2, 0, K_RD | K_MDR, 1, "LD RD done");
    step(0, 1, 4'h2, 0, B_MDR | K_AC, 0, "LD EXI");
    fetch(4'h3, 0); opnd(4'h3);
    step(0, 1, 4'h3, 0, B_MDR | K_MAR, 0, "ST A3");
    step(0, 1, 4'h3, 0, B_R | K_MDR | K_SRC, 0, "ST W1");
    repeat (2) step(0, 0, 4'h3, 0, K_WR, 1, "ST W2 wait");
    step(0, 1, 4'h3, 0, K_WR, 1, "ST W2 done");
    fetch(4'h4, 0); step(0, 1, 4'h4, 0, B_R | K_AC, 0, "MOVR");
    fetch(4'h5, 0); step(0, 1, 4'h5, 0, K_R, 1, "MVAR");
    fetch(4'h6, 0); step(0, 1, 4'h6, 0, B_R | K_AC | A_ADD, 0, "ADD");
    fetch(4'h7, 0); step(0, 1, 4'h7, 0, B_R | K_AC | A_SUB, 0, "SUB");
    fetch(4'h9, 0); opnd(4'h9); step(0, 1, 4'h9, 0, B_MDR, 0, "JZ z=0");
    fetch(4'h9, 0); opnd(4'h9); step(0, 1, 4'h9, 1, B_MDR | K_PC, 0, "JZ z=1");
    fetch(4'h8, 0); opnd(4'h8); step(0, 1, 4'h8, 0, B_MDR | K_PC, 0, "JMP");
    fetch(4'hB, 0);
    fetch(4'h0, 15);
    step(0, 1, 4'h0, 0, K_MAR, 0, "F1 pre-timeout");
    repeat (16) step(0, 0, 4'h0, 0, K_RD, 1, "F2 stuck");
    repeat (3) step(0, 1, 4'h0, 0, K_ERR, 0, "ERR sticky");
    do_reset();
    fetch(4'hF, 0);
    repeat (3) step(0, 1, 4'hF, 0, K_HLT, 0, "HALT");
    do_reset();
    fetch(4'h2, 0); opnd(4'h2);
    step(0, 1, 4'h2, 0, B_MDR | K_MAR, 0, "LD A3");
    step(0, 0, 4'h2, 0, K_RD, 1, "LD RD before reset");
    @(negedge clk);
    #1 reset = 1;
    #1;
    checks++;
    if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
      errors++;
      $display("FAIL async reset drop: mem_rd=%b mem_wr=%b expected 0 0", mem_rd, mem_wr);
    end
    do_reset();
    step(0, 1, 4'h0, 0, K_MAR, 0, "F1 after reset");
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d left expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
